regfile_sb: RTL and testbench

Parametrised dual-bank (integer/floating-point) register file with N read ports, same-cycle write bypass and a per-register scoreboard for long-latency destinations (loads, FPU). Sits in the decode/ID stage of the CPU. Supplies operands to up to three source fields (FMADD-class ops) and raises a RAW hazard when a source is still pending. Writeback and scoreboard updates freeze while the AXI bus stalls the pipeline.

---
 rtl/regfile_pkg.sv | 33 +++
 rtl/regfile_sb_if.sv | 48 ++++
 rtl/rf_bank.sv | 75 +++++++
 rtl/regfile_sb.sv | 118 +++++++++++
 tb/tb_regfile_sb.sv | 199 +++++++++++++++++++
 5 files changed

// File: rtl/regfile_pkg.sv
`default_nettype none
// ============================================================================
// Module   : regfile_pkg
// Brief    : Shared types, defaults and bank-selection helper for the
//            integer / floating-point register file and decode.
// Revision : 1.0 - initial release
// ============================================================================
package regfile_pkg;

    typedef enum logic {
        BANK_INT = 1'b0,
        BANK_FP  = 1'b1
    } bank_e;

    localparam int DEF_XLEN = 32;
    localparam int DEF_NREG = 32;

    localparam logic [6:0] OPC_F_TYPE = 7'b1010011;
    localparam logic [6:0] OPC_FLW    = 7'b0000111;
    localparam logic [6:0] OPC_FSW    = 7'b0100111;

    // Bank of the FP-side register field for an opcode (FLW dest, FSW data, OP-FP).
    function automatic bank_e opcode_to_bank(input logic [6:0] i_opcode);
        bank_e w_bank;
        case (i_opcode)
            OPC_F_TYPE, OPC_FLW, OPC_FSW: w_bank = BANK_FP;
            default:                      w_bank = BANK_INT;
        endcase
        return w_bank;
    endfunction

endpackage
`default_nettype wire

// File: rtl/regfile_sb_if.sv
`default_nettype none
// ============================================================================
// Module   : regfile_sb_if
// Brief    : Read, writeback and issue signals of the register file.
// Revision : 1.0 - initial release
// ============================================================================
interface regfile_sb_if
    import regfile_pkg::*;
#(
    parameter int XLEN = DEF_XLEN,
    parameter int NREG = DEF_NREG,
    parameter int NRD  = 3
) ();
    localparam int c_AW = $clog2(NREG);
    localparam int c_CW = $clog2(2 * NREG + 1);

    logic                           AXI_stall;
    logic [NRD-1:0]                 rd_fp;
    logic [NRD-1:0][c_AW-1:0]       rd_addr;
    logic [NRD-1:0][XLEN-1:0]       rd_data;
    logic [NRD-1:0]                 rd_busy;
    logic [NRD-1:0]                 rd_valid;
    logic                           hazard;
    logic                           wr_en;
    logic                           wr_fp;
    logic [c_AW-1:0]                wr_addr;
    logic [XLEN-1:0]                wr_data;
    logic                           iss_en;
    logic                           iss_fp;
    logic [c_AW-1:0]                iss_addr;
    logic [c_CW-1:0]                pend_cnt;

    modport master (
        output AXI_stall, rd_fp, rd_addr, rd_valid,
        output wr_en, wr_fp, wr_addr, wr_data,
        output iss_en, iss_fp, iss_addr,
        input  rd_data, rd_busy, hazard, pend_cnt
    );

    modport slave (
        input  AXI_stall, rd_fp, rd_addr, rd_valid,
        input  wr_en, wr_fp, wr_addr, wr_data,
        input  iss_en, iss_fp, iss_addr,
        output rd_data, rd_busy, hazard, pend_cnt
    );

endinterface
`default_nettype wire

// File: rtl/rf_bank.sv
`default_nettype none
// ============================================================================
// Module   : rf_bank
// Brief    : One register bank: storage, per-register busy bits and NRD
//            asynchronous read muxes. Optional hard-wired zero register.
// Revision : 1.0 - initial release
// ============================================================================
module rf_bank
    import regfile_pkg::*;
#(
    parameter int XLEN     = DEF_XLEN,
    parameter int NREG     = DEF_NREG,
    parameter int NRD      = 3,
    parameter bit ZERO_REG = 1'b0
) (
    input  wire logic                                clk,
    input  wire logic                                rst,
    input  wire logic                                i_we,
    input  wire logic [$clog2(NREG)-1:0]             i_waddr,
    input  wire logic [XLEN-1:0]                     i_wdata,
    input  wire logic                                i_set,
    input  wire logic [$clog2(NREG)-1:0]             i_saddr,
    input  wire logic [NRD-1:0][$clog2(NREG)-1:0]    i_raddr,
    output logic      [NRD-1:0][XLEN-1:0]            o_rdata,
    output logic      [NRD-1:0]                      o_rbusy,
    output logic                                     o_inc,
    output logic                                     o_dec
);
    logic [XLEN-1:0] r_mem [NREG];
    logic [NREG-1:0] r_busy;

    logic w_we;
    logic w_set;
    logic w_clr;

    assign w_we  = i_we  && !(ZERO_REG && (i_waddr == '0));
    assign w_set = i_set && !(ZERO_REG && (i_saddr == '0));
    // A writeback to a register being re-issued in the same cycle leaves it pending.
    assign w_clr = i_we && !(w_set && (i_saddr == i_waddr));

    assign o_inc = w_set && !r_busy[i_saddr];
    assign o_dec = w_clr &&  r_busy[i_waddr];

    always_ff @(posedge clk) begin
        if (rst) begin
            r_busy <= '0;
            for (int i = 0; i < NREG; i++) begin
                r_mem[i] <= '0;
            end
        end else begin
            if (w_we) begin
                r_mem[i_waddr] <= i_wdata;
            end
            if (w_clr) begin
                r_busy[i_waddr] <= 1'b0;
            end
            if (w_set) begin
                r_busy[i_saddr] <= 1'b1;
            end
        end
    end

    always_comb begin
        o_rdata = '0;
        o_rbusy = '0;
        for (int p = 0; p < NRD; p++) begin
            if (!(ZERO_REG && (i_raddr[p] == '0))) begin
                o_rdata[p] = r_mem[i_raddr[p]];
                o_rbusy[p] = r_busy[i_raddr[p]];
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/regfile_sb.sv
`default_nettype none
// ============================================================================
// Module   : regfile_sb
// Brief    : Dual-bank (int/FP) register file with N read ports, same-cycle
//            write bypass, busy scoreboard, RAW hazard and pending counter.
// Revision : 1.0 - initial release
// ============================================================================
module regfile_sb
    import regfile_pkg::*;
#(
    parameter int XLEN   = DEF_XLEN,
    parameter int NREG   = DEF_NREG,
    parameter int NRD    = 3,
    parameter int BYPASS = 1
) (
    input  wire logic     clk,
    input  wire logic     rst,
    regfile_sb_if.slave   bus
);
    localparam int c_AW  = $clog2(NREG);
    localparam int c_CW  = $clog2(2 * NREG + 1);
    localparam bit c_BYP = (BYPASS != 0);

    logic                     w_wr_go;
    logic                     w_iss_go;
    logic                     w_wr_x0;
    logic                     w_we_int,  w_we_fp;
    logic                     w_set_int, w_set_fp;
    logic                     w_inc_int, w_inc_fp;
    logic                     w_dec_int, w_dec_fp;
    logic [NRD-1:0][XLEN-1:0] w_int_rdata, w_fp_rdata;
    logic [NRD-1:0]           w_int_rbusy, w_fp_rbusy;
    logic [NRD-1:0]           w_byp;
    logic [NRD-1:0]           w_reiss;
    logic [NRD-1:0][XLEN-1:0] w_rd_data;
    logic [NRD-1:0]           w_rd_busy;
    logic [c_CW-1:0]          r_pend_cnt;

    assign w_wr_go   = bus.wr_en  && !bus.AXI_stall;
    assign w_iss_go  = bus.iss_en && !bus.AXI_stall;
    assign w_wr_x0   = (bank_e'(bus.wr_fp) == BANK_INT) && (bus.wr_addr == '0);

    assign w_we_int  = w_wr_go  && (bank_e'(bus.wr_fp)  == BANK_INT);
    assign w_we_fp   = w_wr_go  && (bank_e'(bus.wr_fp)  == BANK_FP);
    assign w_set_int = w_iss_go && (bank_e'(bus.iss_fp) == BANK_INT);
    assign w_set_fp  = w_iss_go && (bank_e'(bus.iss_fp) == BANK_FP);

    rf_bank #(.XLEN(XLEN), .NREG(NREG), .NRD(NRD), .ZERO_REG(1'b1)) u_bank_int (
        .clk     (clk),
        .rst     (rst),
        .i_we    (w_we_int),
        .i_waddr (bus.wr_addr),
        .i_wdata (bus.wr_data),
        .i_set   (w_set_int),
        .i_saddr (bus.iss_addr),
        .i_raddr (bus.rd_addr),
        .o_rdata (w_int_rdata),
        .o_rbusy (w_int_rbusy),
        .o_inc   (w_inc_int),
        .o_dec   (w_dec_int)
    );

    rf_bank #(.XLEN(XLEN), .NREG(NREG), .NRD(NRD), .ZERO_REG(1'b0)) u_bank_fp (
        .clk     (clk),
        .rst     (rst),
        .i_we    (w_we_fp),
        .i_waddr (bus.wr_addr),
        .i_wdata (bus.wr_data),
        .i_set   (w_set_fp),
        .i_saddr (bus.iss_addr),
        .i_raddr (bus.rd_addr),
        .o_rdata (w_fp_rdata),
        .o_rbusy (w_fp_rbusy),
        .o_inc   (w_inc_fp),
        .o_dec   (w_dec_fp)
    );

    // A bypassed writeback makes the value available, unless the register is re-issued now.
    always_comb begin
        w_byp     = '0;
        w_reiss   = '0;
        w_rd_data = '0;
        w_rd_busy = '0;
        for (int p = 0; p < NRD; p++) begin
            w_byp[p]   = c_BYP && w_wr_go && !w_wr_x0 &&
                         (bus.wr_fp == bus.rd_fp[p]) && (bus.wr_addr == bus.rd_addr[p]);
            w_reiss[p] = w_iss_go &&
                         (bus.iss_fp == bus.rd_fp[p]) && (bus.iss_addr == bus.rd_addr[p]);
            if (w_byp[p]) begin
                w_rd_data[p] = bus.wr_data;
            end else begin
                w_rd_data[p] = bus.rd_fp[p] ? w_fp_rdata[p] : w_int_rdata[p];
            end
            if (w_byp[p] && !w_reiss[p]) begin
                w_rd_busy[p] = 1'b0;
            end else begin
                w_rd_busy[p] = bus.rd_fp[p] ? w_fp_rbusy[p] : w_int_rbusy[p];
            end
        end
    end

    assign bus.rd_data = w_rd_data;
    assign bus.rd_busy = w_rd_busy;
    assign bus.hazard  = |(w_rd_busy & bus.rd_valid);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_pend_cnt <= '0;
        end else begin
            r_pend_cnt <= r_pend_cnt + c_CW'(w_inc_int) + c_CW'(w_inc_fp)
                                     - c_CW'(w_dec_int) - c_CW'(w_dec_fp);
        end
    end

    assign bus.pend_cnt = r_pend_cnt;

endmodule
`default_nettype wire

// File: tb/tb_regfile_sb.sv
`default_nettype none
// ============================================================================
// Module   : tb_regfile_sb
// Brief    : Self-checking bench driving a bypass and a non-bypass instance
//            of regfile_sb with identical stimulus from a vector table.
// Revision : 1.0 - initial release
// ============================================================================
module tb_regfile_sb;
    import regfile_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    regfile_sb_if #(.XLEN(32), .NREG(32), .NRD(3)) bus_b ();
    regfile_sb_if #(.XLEN(32), .NREG(32), .NRD(3)) bus_n ();

    regfile_sb #(.XLEN(32), .NREG(32), .NRD(3), .BYPASS(1)) u_dut_byp (
        .clk (clk),
        .rst (rst),
        .bus (bus_b)
    );

    regfile_sb #(.XLEN(32), .NREG(32), .NRD(3), .BYPASS(0)) u_dut_nobyp (
        .clk (clk),
        .rst (rst),
        .bus (bus_n)
    );

    // chk: 0 = no check, 1 = full check, 2 = pend_cnt only
    typedef struct {
        string            name;
        logic [1:0]       chk;
        logic             rst;
        logic             stall;
        logic             wen;
        logic             wfp;
        logic [4:0]       wa;
        logic [31:0]      wd;
        logic             ien;
        logic             ifp;
        logic [4:0]       ia;
        logic [2:0]       rfp;
        logic [2:0][4:0]  ra;
        logic [2:0]       rv;
        logic [2:0][31:0] ed;
        logic [2:0]       eb;
        logic             eh;
        logic [6:0]       ec;
        logic [31:0]      nd0;
        logic             nb0;
    } vec_t;

    vec_t tv[$];
    vec_t sb[$];
    int   checks = 0;
    int   errors = 0;

    function automatic vec_t idle(string name);
        vec_t v;
        v.name = name; v.chk = 2'd0; v.rst = 1'b0; v.stall = 1'b0;
        v.wen = 1'b0; v.wfp = 1'b0; v.wa = '0; v.wd = '0;
        v.ien = 1'b0; v.ifp = 1'b0; v.ia = '0;
        v.rfp = '0; v.ra = '0; v.rv = '0;
        v.ed = '0; v.eb = '0; v.eh = 1'b0; v.ec = '0; v.nd0 = '0; v.nb0 = 1'b0;
        return v;
    endfunction

    function automatic void add(string name, logic [1:0] chk, logic r, logic st,
                                logic wen, logic wfp, int wa, logic [31:0] wd,
                                logic ien, logic ifp, int ia,
                                logic [2:0] rfp, int a0, int a1, int a2, logic [2:0] rv,
                                logic [31:0] d0, logic [31:0] d1, logic [31:0] d2,
                                logic [2:0] eb, logic eh, int ec, logic [31:0] nd0, logic nb0);
        vec_t v = idle(name);
        v.chk = chk; v.rst = r; v.stall = st;
        v.wen = wen; v.wfp = wfp; v.wa = 5'(wa); v.wd = wd;
        v.ien = ien; v.ifp = ifp; v.ia = 5'(ia);
        v.rfp = rfp; v.ra[0] = 5'(a0); v.ra[1] = 5'(a1); v.ra[2] = 5'(a2); v.rv = rv;
        v.ed[0] = d0; v.ed[1] = d1; v.ed[2] = d2;
        v.eb = eb; v.eh = eh; v.ec = 7'(ec); v.nd0 = nd0; v.nb0 = nb0;
        tv.push_back(v);
    endfunction

    task automatic drive(input vec_t v);
        rst = v.rst;
        bus_b.AXI_stall = v.stall; bus_n.AXI_stall = v.stall;
        bus_b.wr_en = v.wen;       bus_n.wr_en = v.wen;
        bus_b.wr_fp = v.wfp;       bus_n.wr_fp = v.wfp;
        bus_b.wr_addr = v.wa;      bus_n.wr_addr = v.wa;
        bus_b.wr_data = v.wd;      bus_n.wr_data = v.wd;
        bus_b.iss_en = v.ien;      bus_n.iss_en = v.ien;
        bus_b.iss_fp = v.ifp;      bus_n.iss_fp = v.ifp;
        bus_b.iss_addr = v.ia;     bus_n.iss_addr = v.ia;
        bus_b.rd_fp = v.rfp;       bus_n.rd_fp = v.rfp;
        bus_b.rd_addr = v.ra;      bus_n.rd_addr = v.ra;
        bus_b.rd_valid = v.rv;     bus_n.rd_valid = v.rv;
    endtask

    function automatic void chk32(string n, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", n, act, exp);
        end
    endfunction

    function automatic void check_sb();
        vec_t e;
        if (sb.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL scoreboard: got empty queue expected an entry");
            return;
        end
        e = sb.pop_front();
        if (e.chk == 2'd1) begin
            for (int p = 0; p < 3; p++) begin
                chk32($sformatf("%s.data%0d", e.name, p), bus_b.rd_data[p], e.ed[p]);
            end
            chk32({e.name, ".busy"},   {29'b0, bus_b.rd_busy}, {29'b0, e.eb});
            chk32({e.name, ".hazard"}, {31'b0, bus_b.hazard},  {31'b0, e.eh});
            chk32({e.name, ".nb_data0"}, bus_n.rd_data[0], e.nd0);
            chk32({e.name, ".nb_busy0"}, {31'b0, bus_n.rd_busy[0]}, {31'b0, e.nb0});
        end
        if (e.chk != 2'd0) begin
            chk32({e.name, ".pend_cnt"},    {25'b0, bus_b.pend_cnt}, {25'b0, e.ec});
            chk32({e.name, ".nb_pend_cnt"}, {25'b0, bus_n.pend_cnt}, {25'b0, e.ec});
        end
    endfunction

    task automatic run(input vec_t v);
        @(posedge clk);
        #1;
        drive(v);
        sb.push_back(v);
        @(negedge clk);
        check_sb();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t h;
        //   name          chk rst st  wen wfp wa wd            ien ifp ia  rfp    a0 a1 a2 rv      d0            d1            d2     eb     eh ec nd0           nb0
        add("reset",       0, 1, 0,  0, 0, 0, 0,             0, 0, 0,  3'b000, 0, 0, 0, 3'b000, 0,            0,            0,     3'b000, 0, 0, 0,            0);
        add("x0_write",    1, 0, 0,  1, 0, 0, 32'hDEADBEEF,  0, 0, 0,  3'b010, 0, 0,31, 3'b000, 0,            0,            0,     3'b000, 0, 0, 0,            0);
        add("x0_read",     1, 0, 0,  0, 0, 0, 0,             0, 0, 0,  3'b010, 0,31, 1, 3'b000, 0,            0,            0,     3'b000, 0, 0, 0,            0);
        add("f5_bypass",   1, 0, 0,  1, 1, 5, 32'h3F800000,  0, 0, 0,  3'b101, 5, 5, 4, 3'b000, 32'h3F800000, 0,            0,     3'b000, 0, 0, 0,            0);
        add("f5_array",    1, 0, 0,  0, 0, 0, 0,             1, 0, 7,  3'b001, 5, 5, 7, 3'b100, 32'h3F800000, 0,            0,     3'b000, 0, 0, 32'h3F800000, 0);
        add("x7_hazard",   1, 0, 0,  0, 0, 0, 0,             0, 0, 0,  3'b010, 7, 5, 0, 3'b001, 0,            32'h3F800000, 0,     3'b001, 1, 1, 0,            1);
        add("x7_wb",       1, 0, 0,  1, 0, 7, 32'h12,        0, 0, 0,  3'b110, 7, 5, 7, 3'b011, 32'h12,       32'h3F800000, 0,     3'b000, 0, 1, 0,            1);
        add("x7_after",    1, 0, 0,  0, 0, 0, 0,             0, 0, 0,  3'b000, 7, 3, 0, 3'b001, 32'h12,       0,            0,     3'b000, 0, 0, 32'h12,       0);
        add("f3_issue",    1, 0, 0,  0, 0, 0, 0,             1, 1, 3,  3'b101, 3, 7, 5, 3'b001, 0,            32'h12,  32'h3F800000, 3'b000, 0, 0, 0,            0);
        add("f3_set_clr",  1, 0, 0,  1, 1, 3, 32'hAAAA,      1, 1, 3,  3'b001, 3, 3, 7, 3'b001, 32'hAAAA,     0,            32'h12, 3'b001, 1, 1, 0,           1);
        add("f3_reissue",  1, 0, 0,  0, 0, 0, 0,             1, 1, 3,  3'b001, 3, 3, 7, 3'b001, 32'hAAAA,     0,            32'h12, 3'b001, 1, 1, 32'hAAAA,    1);
        add("stall",       1, 0, 1,  1, 1, 3, 32'h5555,      1, 0, 9,  3'b001, 3, 9, 7, 3'b011, 32'hAAAA,     0,            32'h12, 3'b001, 1, 1, 32'hAAAA,    1);
        add("unstall",     1, 0, 0,  1, 1, 3, 32'h5555,      1, 0, 9,  3'b001, 3, 9, 7, 3'b011, 32'h5555,     0,            32'h12, 3'b000, 0, 1, 32'hAAAA,    1);
        add("x9_busy",     1, 0, 0,  0, 0, 0, 0,             1, 0,10,  3'b001, 3, 9, 0, 3'b111, 32'h5555,     0,            0,     3'b010, 1, 1, 32'h5555,     0);
        add("valid_mask",  1, 0, 0,  0, 0, 0, 0,             1, 0, 0,  3'b000, 0, 9,10, 3'b001, 0,            0,            0,     3'b110, 0, 2, 0,            0);
        add("f10_issue",   1, 0, 0,  0, 0, 0, 0,             1, 1,10,  3'b001,10, 9,10, 3'b000, 0,            0,            0,     3'b110, 0, 2, 0,            0);
        add("f11_issue",   1, 0, 0,  0, 0, 0, 0,             1, 1,11,  3'b011,10,11,12, 3'b001, 0,            0,            0,     3'b001, 1, 3, 0,            1);
        add("x12_issue",   1, 0, 0,  0, 0, 0, 0,             1, 0,12,  3'b011,10,11,12, 3'b000, 0,            0,            0,     3'b011, 0, 4, 0,            1);
        add("rst_mid",     1, 1, 0,  0, 0, 0, 0,             1, 1,12,  3'b010,12,11, 9, 3'b111, 0,            0,            0,     3'b111, 1, 5, 0,            1);
        add("post_rst",    1, 0, 0,  1, 0, 7, 32'h77,        0, 0, 0,  3'b110, 7, 3, 5, 3'b111, 32'h77,       0,            0,     3'b000, 0, 0, 0,            0);
        add("post_rst2",   1, 0, 0,  0, 0, 0, 0,             0, 0, 0,  3'b110, 7, 3, 5, 3'b111, 32'h77,       0,            0,     3'b000, 0, 0, 32'h77,       0);

        drive(idle("init"));
        rst = 1'b1;
        for (int i = 0; i < tv.size(); i++) begin
            run(tv[i]);
        end

        // Cross-bank increment and decrement landing on the same edge.
        h = idle("seq_iss_x1");     h.chk = 2'd2; h.ien = 1'b1; h.ia = 5'd1; h.ec = 7'd0;
        run(h);
        h = idle("seq_iss_f2_wb_x1"); h.chk = 2'd2; h.ien = 1'b1; h.ifp = 1'b1; h.ia = 5'd2;
        h.wen = 1'b1; h.wa = 5'd1; h.wd = 32'h11; h.ec = 7'd1;
        run(h);
        h = idle("seq_wb_f2");      h.chk = 2'd2; h.wen = 1'b1; h.wfp = 1'b1; h.wa = 5'd2;
        h.wd = 32'h22; h.ec = 7'd1;
        run(h);
        // Writeback to a register that was never pending must not decrement.
        h = idle("seq_wb_idle_x20"); h.chk = 2'd2; h.wen = 1'b1; h.wa = 5'd20;
        h.wd = 32'h20; h.ec = 7'd0;
        run(h);
        h = idle("seq_final");      h.chk = 2'd2; h.ec = 7'd0;
        run(h);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
